// File: rtl/draw_pkg.sv
// Shared types and constants for the line-drawing scheduler: FSM states,
// coordinate/length/colour widths, screen limits and the line-command record.
package draw_pkg;
    localparam int X_W       = 10;
    localparam int Y_W       = 9;
    localparam int LEN_W     = 8;
    localparam int COLOR_W   = 3;
    localparam int X_MAX_DEF = 639;
    localparam int Y_MAX_DEF = 479;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [LEN_W-1:0]   len;
        logic               vert;
        logic [COLOR_W-1:0] color;
    } line_cmd_t;

    function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                       input int xmax, input int ymax);
        return (int'(x) <= xmax) && (int'(y) <= ymax);
    endfunction
endpackage

// File: rtl/draw_scheduler_if.sv
// Client command bus plus pixel-writer outputs of the draw scheduler.
// master = clients/framebuffer side, slave = scheduler.
interface draw_if
    import draw_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*X_W-1:0]     req_x;
    logic [NUM_REQ*Y_W-1:0]     req_y;
    logic [NUM_REQ*LEN_W-1:0]   req_len;
    logic [NUM_REQ-1:0]         req_vert;
    logic [NUM_REQ*COLOR_W-1:0] req_color;
    logic [X_W-1:0]             CounterX;
    logic [Y_W-1:0]             CounterY;
    logic [COLOR_W-1:0]         color;
    logic                       pix_we;
    logic                       busy;
    logic                       done;
    logic [ID_W-1:0]            done_id;

    modport master (
        output req_valid, req_x, req_y, req_len, req_vert, req_color,
        input  req_ready, CounterX, CounterY, color, pix_we, busy, done, done_id
    );

    modport slave (
        input  req_valid, req_x, req_y, req_len, req_vert, req_color,
        output req_ready, CounterX, CounterY, color, pix_we, busy, done, done_id
    );
endinterface

// File: rtl/draw_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first valid
// requester at or above the pointer, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant
);
    // Walk from the farthest offset back to the pointer so the closest valid wins.
    always_comb begin
        int idx;
        o_grant = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (int'(i_ptr) + off) % NUM_REQ;
            if (i_valid[idx]) begin
                o_grant      = '0;
                o_grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/draw_scheduler.sv
// Shares one pixel-write port among NUM_REQ line clients; the granted line is
// rasterised one pixel per clock. Define DRAW_SCHED_PRIO_EN to give client 0 fixed priority.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int X_MAX   = X_MAX_DEF,
    parameter int Y_MAX   = Y_MAX_DEF
) (
    input logic  clk,
    input logic  rst,
    draw_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             r_state, w_state_next;
    line_cmd_t          w_cmd [NUM_REQ];
    logic [NUM_REQ-1:0] w_arb_valid, w_rr_grant, w_grant;
    logic [ID_W-1:0]    r_ptr, w_ptr_next, w_id;
    logic               w_accept, w_ptr_upd;

    logic [X_W-1:0]     r_cx, w_cx_next;
    logic [Y_W-1:0]     r_cy, w_cy_next;
    logic [COLOR_W-1:0] r_color, w_color_next;
    logic               r_we, w_we_next;
    logic               r_done, w_done_next;
    logic [ID_W-1:0]    r_done_id, w_done_id_next;
    logic [ID_W-1:0]    r_id, w_id_next;
    logic               r_vert, w_vert_next;
    logic               r_wrap, w_wrap_next;
    logic [LEN_W-1:0]   r_rem, w_rem_next;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_cmd[gi] = '{x:     bus.req_x[gi*X_W +: X_W],
                             y:     bus.req_y[gi*Y_W +: Y_W],
                             len:   bus.req_len[gi*LEN_W +: LEN_W],
                             vert:  bus.req_vert[gi],
                             color: bus.req_color[gi*COLOR_W +: COLOR_W]};
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_valid (w_arb_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant)
    );

`ifdef DRAW_SCHED_PRIO_EN
    // Client 0 bypasses the rotation and never moves the pointer.
    assign w_arb_valid = bus.req_valid & {{(NUM_REQ-1){1'b1}}, 1'b0};
    assign w_grant     = bus.req_valid[0] ? {{(NUM_REQ-1){1'b0}}, 1'b1} : w_rr_grant;
    assign w_ptr_upd   = w_accept && !bus.req_valid[0];
`else
    assign w_arb_valid = bus.req_valid;
    assign w_grant     = w_rr_grant;
    assign w_ptr_upd   = w_accept;
`endif

    always_comb begin
        w_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) w_id = ID_W'(i);
        end
    end

    assign w_accept      = (r_state == IDLE) && (|w_grant);
    assign w_ptr_next    = w_ptr_upd ? ID_W'((int'(w_id) + 1) % NUM_REQ) : r_ptr;
    assign bus.req_ready = (rst && r_state == IDLE) ? w_grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = DRAW;
            DRAW:    if (r_rem == '0) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Pixel 0 is registered straight from the request at the accept edge;
    // r_rem counts the pixels still to come after the one on the outputs.
    always_comb begin
        line_cmd_t  c;
        logic [X_W:0] nx;
        logic [Y_W:0] ny;
        c              = w_cmd[w_id];
        nx             = '0;
        ny             = '0;
        w_cx_next      = '0;
        w_cy_next      = '0;
        w_color_next   = '0;
        w_we_next      = 1'b0;
        w_done_next    = 1'b0;
        w_done_id_next = '0;
        w_rem_next     = r_rem;
        w_id_next      = r_id;
        w_vert_next    = r_vert;
        w_wrap_next    = r_wrap;
        case (r_state)
            IDLE: if (w_accept) begin
                w_cx_next      = c.x;
                w_cy_next      = c.y;
                w_color_next   = c.color;
                w_rem_next     = (c.len == '0) ? '0 : c.len - LEN_W'(1);
                w_id_next      = w_id;
                w_vert_next    = c.vert;
                w_wrap_next    = 1'b0;
                w_we_next      = (c.len != '0) && on_screen(c.x, c.y, X_MAX, Y_MAX);
                w_done_next    = (c.len <= LEN_W'(1));
                w_done_id_next = (c.len <= LEN_W'(1)) ? w_id : '0;
            end
            DRAW: if (r_rem != '0) begin
                nx             = {1'b0, r_cx} + {{X_W{1'b0}}, !r_vert};
                ny             = {1'b0, r_cy} + {{Y_W{1'b0}}, r_vert};
                w_cx_next      = nx[X_W-1:0];
                w_cy_next      = ny[Y_W-1:0];
                w_color_next   = r_color;
                // A coordinate that wrapped stays off-screen for the rest of the line.
                w_wrap_next    = r_wrap | nx[X_W] | ny[Y_W];
                w_rem_next     = r_rem - LEN_W'(1);
                w_we_next      = !w_wrap_next && on_screen(w_cx_next, w_cy_next, X_MAX, Y_MAX);
                w_done_next    = (r_rem == LEN_W'(1));
                w_done_id_next = (r_rem == LEN_W'(1)) ? r_id : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cx      <= '0;
            r_cy      <= '0;
            r_color   <= '0;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_id      <= '0;
            r_vert    <= 1'b0;
            r_wrap    <= 1'b0;
            r_rem     <= '0;
        end else begin
            r_cx      <= w_cx_next;
            r_cy      <= w_cy_next;
            r_color   <= w_color_next;
            r_we      <= w_we_next;
            r_done    <= w_done_next;
            r_done_id <= w_done_id_next;
            r_id      <= w_id_next;
            r_vert    <= w_vert_next;
            r_wrap    <= w_wrap_next;
            r_rem     <= w_rem_next;
        end
    end

    assign bus.CounterX = r_cx;
    assign bus.CounterY = r_cy;
    assign bus.color    = r_color;
    assign bus.pix_we   = r_we;
    assign bus.done     = r_done;
    assign bus.done_id  = r_done_id;
    assign bus.busy     = (r_state == DRAW);
endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: directed scenarios plus random commands, checked
// against a model of grant order and per-pixel output from the line rules.
module tb_draw_scheduler;
    import draw_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    draw_if #(.NUM_REQ(4)) bus ();
    draw_scheduler #(.NUM_REQ(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int        n_pass  = 0;
    int        n_total = 0;
    int        n_fail  = 0;
    int        m_ptr   = 0;
    logic [3:0] p_valid;
    line_cmd_t  p_cmd [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic line_cmd_t rand_cmd();
        line_cmd_t c;
        case ($urandom_range(3, 0))
            0:       c.x = 10'($urandom_range(1023, 1012));
            1:       c.x = 10'($urandom_range(639, 630));
            default: c.x = 10'($urandom);
        endcase
        case ($urandom_range(3, 0))
            0:       c.y = 9'($urandom_range(511, 502));
            1:       c.y = 9'($urandom_range(479, 470));
            default: c.y = 9'($urandom);
        endcase
        c.len   = 8'($urandom_range(12, 0));
        c.vert  = 1'($urandom);
        c.color = 3'($urandom);
        return c;
    endfunction

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid[i]          = p_valid[i];
            bus.req_x[i*X_W +: X_W]   = p_cmd[i].x;
            bus.req_y[i*Y_W +: Y_W]   = p_cmd[i].y;
            bus.req_len[i*LEN_W +: LEN_W] = p_cmd[i].len;
            bus.req_vert[i]           = p_cmd[i].vert;
            bus.req_color[i*COLOR_W +: COLOR_W] = p_cmd[i].color;
        end
    endtask

    function automatic int model_pick();
        int pick = -1;
`ifdef DRAW_SCHED_PRIO_EN
        if (p_valid[0]) return 0;
`endif
        for (int off = 0; off < 4; off++) begin
            int c;
            c = (m_ptr + off) % 4;
            if (p_valid[c] && pick < 0) pick = c;
        end
        return pick;
    endfunction

    task automatic model_accept(input int g);
`ifdef DRAW_SCHED_PRIO_EN
        if (g != 0) m_ptr = (g + 1) % 4;
`else
        m_ptr = (g + 1) % 4;
`endif
    endtask

    // Expected output for slot k of a command: true position decides clipping,
    // presented coordinate is the position modulo the counter width.
    task automatic check_pixel(input line_cmd_t c, input int id, input int k);
        int n, tx, ty;
        logic last, we;
        n    = (c.len == 0) ? 1 : int'(c.len);
        tx   = int'(c.x) + (c.vert ? 0 : k);
        ty   = int'(c.y) + (c.vert ? k : 0);
        last = (k == n - 1);
        we   = (k < int'(c.len)) && (tx <= 639) && (ty <= 479);
        $display("pixel id=%0d k=%0d exp=(%0d,%0d) we=%0b done=%0b got=(%0d,%0d) we=%0b done=%0b",
                 id, k, tx % 1024, ty % 512, we, last, bus.CounterX, bus.CounterY, bus.pix_we, bus.done);
        check("busy_draw", 32'(bus.busy), 32'd1);
        check("ready_draw", 32'(bus.req_ready), 32'd0);
        check("pix_we", 32'(bus.pix_we), 32'(we));
        check("done", 32'(bus.done), 32'(last));
        check("done_id", 32'(bus.done_id), last ? 32'(id) : 32'd0);
        if (k < int'(c.len)) begin
            check("x", 32'(bus.CounterX), 32'(tx % 1024));
            check("y", 32'(bus.CounterY), 32'(ty % 512));
            check("color", 32'(bus.color), 32'(c.color));
        end
    endtask

    // Entered at a negedge in an IDLE cycle; leaves at the next IDLE negedge.
    // mode 0: client drops its request after accept, 1: posts a new random command.
    task automatic serve_one(input int mode);
        int g, n;
        line_cmd_t c;
        #1;
        g = model_pick();
        $display("idle ptr=%0d valid=%b exp_grant=%0d ready=%b", m_ptr, p_valid, g, bus.req_ready);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("we_idle", 32'(bus.pix_we), 32'd0);
        check("ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        if (g < 0) begin
            @(negedge clk);
            return;
        end
        c = p_cmd[g];
        model_accept(g);
        @(posedge clk);
        #1;
        if (mode == 1) p_cmd[g] = rand_cmd();
        else           p_valid[g] = 1'b0;
        apply();
        n = (c.len == 0) ? 1 : int'(c.len);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_pixel(c, g, k);
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_we"}, 32'(bus.pix_we), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_done_id"}, 32'(bus.done_id), 32'd0);
        check({tag, "_x"}, 32'(bus.CounterX), 32'd0);
        check({tag, "_y"}, 32'(bus.CounterY), 32'd0);
        check({tag, "_color"}, 32'(bus.color), 32'd0);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        m_ptr = 0;
        #1;
        $display("reset asserted valid=%b", p_valid);
        check_zero("rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        line_cmd_t c;
        p_valid = '0;
        for (int i = 0; i < 4; i++) p_cmd[i] = '0;
        apply();

        do_reset();

        p_cmd[1] = '{x: 10'd5, y: 9'd100, len: 8'd4, vert: 1'b1, color: 3'd7};
        p_valid  = 4'b0010;
        apply();
        serve_one(0);
        check("busy_after_t1", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 4; i++) p_cmd[i] = rand_cmd();
        p_valid = 4'b1111;
        apply();
        do_reset();
        for (int i = 0; i < 5; i++) serve_one(1);

        p_valid  = 4'b1000;
        p_cmd[3] = '{x: 10'd638, y: 9'd20, len: 8'd4, vert: 1'b0, color: 3'd3};
        apply();
        serve_one(0);

        p_valid  = 4'b0100;
        p_cmd[2] = '{x: 10'd10, y: 9'd10, len: 8'd0, vert: 1'b0, color: 3'd1};
        apply();
        serve_one(0);

        p_valid  = 4'b0001;
        c        = '{x: 10'd50, y: 9'd60, len: 8'd10, vert: 1'b0, color: 3'd5};
        p_cmd[0] = c;
        apply();
        #1;
        check("mid_ready", 32'(bus.req_ready), 32'd1);
        model_accept(0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_pixel(c, 0, 0);
        @(negedge clk);
        check_pixel(c, 0, 1);
        @(posedge clk);
        #1;
        check("mid_we_px2", 32'(bus.pix_we), 32'd1);
        check("mid_x_px2", 32'(bus.CounterX), 32'd52);
        rst = 1'b0;
        #1;
        $display("reset mid-draw");
        check_zero("midrst");
        m_ptr = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        serve_one(0);

        p_valid  = 4'b1001;
        p_cmd[0] = rand_cmd();
        p_cmd[3] = rand_cmd();
        apply();
        for (int i = 0; i < 4; i++) serve_one(1);

        p_valid = '0;
        apply();
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (!p_valid[i] && $urandom_range(1, 0) == 1) begin
                    p_cmd[i]   = rand_cmd();
                    p_valid[i] = 1'b1;
                end
            end
            apply();
            serve_one(int'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
